i2s_sink: RTL and testbench

- Oversampling I2S receiver. Consumes bck/lrck/sdata, either from an external ADC or from the testbench I2S source in loopback, in the system clock domain.
- Deserializes one left/right pair per LRCK frame and presents it as a 48-bit {left, right} word on a valid/ready port that feeds the capture FIFO.
- Flags malformed frames and dropped samples.
- Synthesizable; no clocks are derived from bck.

---
 rtl/i2s_sink.sv | 209 ++++++++++++++++++++
 tb/tb_i2s_sink.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sink.sv
// Oversampling I2S receiver. bck/lrck/sdata are synchronized into the clk domain and bck
// rising edges are detected by oversampling, so no logic is clocked from bck. One
// {left, right} pair is deserialized per LRCK frame and offered on a valid/ready port.
//
// Ports:
//   clk          system clock, at least 4x the bck frequency
//   reset_n      asynchronous active-low reset
//   enable       capture enable; low forces IDLE and drops any partial pair
//   bck          I2S bit clock (asynchronous to clk)
//   lrck         word clock, 0 = left slot, 1 = right slot
//   sdata        serial data, MSB first, sampled on bck rising edges
//   out_data     {left, right}, left in the MSBs
//   out_valid    out_data holds an unconsumed pair
//   out_ready    consumer accepts when out_valid && out_ready at a clk edge
//   frame_error  one-cycle pulse: a channel slot ended before SAMPLE_BITS bits arrived
//   overflow     sticky: a completed pair was dropped while out_valid was held
module i2s_sink #(
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned MSB_DELAY   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     bck,
  input  logic                     lrck,
  input  logic                     sdata,
  output logic [2*SAMPLE_BITS-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_error,
  output logic                     overflow
);

  localparam int unsigned PairW = 2 * SAMPLE_BITS;
  localparam int unsigned CntW  = $clog2(SAMPLE_BITS + MSB_DELAY + 1);

  // Edge index at which a slot holds all its bits; the counter saturates here.
  localparam logic [CntW-1:0] CntMax   = CntW'(SAMPLE_BITS + MSB_DELAY);
  localparam logic [CntW-1:0] CntFirst = CntW'(MSB_DELAY);

  typedef enum logic [1:0] {StIdle, StLeft, StRight} state_e;

  // Input synchronizers and bck edge detection
  logic [SYNC_STAGES-1:0] bck_sync_q, lrck_sync_q, sdata_sync_q;
  logic                   bck_dly_q;
  logic                   bck_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bck_sync_q   <= '0;
      lrck_sync_q  <= '0;
      sdata_sync_q <= '0;
      bck_dly_q    <= 1'b0;
    end else begin
      bck_sync_q   <= {bck_sync_q[SYNC_STAGES-2:0], bck};
      lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], lrck};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
      bck_dly_q    <= bck_sync_q[SYNC_STAGES-1];
    end
  end

  assign bck_rise = bck_sync_q[SYNC_STAGES-1] & ~bck_dly_q;

  // Register the rise event with lrck/sdata from the same synced stage.
  logic rise_q, lrck_smp_q, sdata_smp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q      <= 1'b0;
      lrck_smp_q  <= 1'b0;
      sdata_smp_q <= 1'b0;
    end else begin
      rise_q      <= bck_rise;
      lrck_smp_q  <= lrck_sync_q[SYNC_STAGES-1];
      sdata_smp_q <= sdata_sync_q[SYNC_STAGES-1];
    end
  end

  // Slot tracking
  logic                   lrck_prev_q;
  logic [CntW-1:0]        idx_q;      // index the next bck rise in this slot will have
  logic [CntW-1:0]        edge_idx;   // index of the rise being processed now
  logic                   lrck_edge, lrck_fall, lrck_rise;
  logic                   slot_full, at_or_past_msb, capture;
  logic [SAMPLE_BITS-1:0] shift_q, left_q;
  logic [PairW-1:0]       pair_q;
  logic                   done_q, frame_error_q;

  assign lrck_edge = rise_q && (lrck_smp_q != lrck_prev_q);
  assign lrck_fall = lrck_edge && !lrck_smp_q;
  assign lrck_rise = lrck_edge && lrck_smp_q;
  assign edge_idx  = lrck_edge ? '0 : idx_q;
  assign slot_full = (idx_q == CntMax);

  if (MSB_DELAY == 0) begin : g_no_delay
    assign at_or_past_msb = 1'b1;
  end else begin : g_delay
    assign at_or_past_msb = (edge_idx >= CntFirst);
  end

  // Bits past the sample window in a long slot are ignored.
  assign capture = rise_q && at_or_past_msb && (edge_idx < CntMax);

  // FSM: state register, next state, outputs
  state_e state_q, state_d;
  logic   pair_done, frame_err_d, left_load, left_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (lrck_fall) state_d = StLeft;
        StLeft:  if (lrck_rise) state_d = slot_full ? StRight : StIdle;
        // A short right slot still re-syncs on this falling lrck edge.
        StRight: if (lrck_fall) state_d = StLeft;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    pair_done   = 1'b0;
    frame_err_d = 1'b0;
    left_load   = 1'b0;
    left_clear  = 1'b0;
    if (enable) begin
      case (state_q)
        StLeft: begin
          if (lrck_rise) begin
            if (slot_full) left_load   = 1'b1;
            else           frame_err_d = 1'b1;
          end
        end
        StRight: begin
          if (lrck_fall) begin
            if (slot_full) begin
              pair_done = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              left_clear  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Deserializer datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrck_prev_q   <= 1'b0;
      idx_q         <= '0;
      shift_q       <= '0;
      left_q        <= '0;
      pair_q        <= '0;
      done_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (rise_q) begin
        lrck_prev_q <= lrck_smp_q;
        if (lrck_edge)           idx_q <= CntW'(1);
        else if (idx_q != CntMax) idx_q <= idx_q + 1'b1;
      end
      // shift_q holds the finished slot until the edge's own bit lands (matters for MSB_DELAY=0).
      if (capture) shift_q <= {shift_q[SAMPLE_BITS-2:0], sdata_smp_q};
      if (left_load)       left_q <= shift_q;
      else if (left_clear) left_q <= '0;
      if (pair_done) pair_q <= {left_q, shift_q};
      done_q        <= pair_done;
      frame_error_q <= frame_err_d;
    end
  end

  // Output port
  logic [PairW-1:0] out_data_q;
  logic             out_valid_q, overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (done_q) begin
      if (!out_valid_q || out_ready) begin
        out_data_q  <= pair_q;
        out_valid_q <= 1'b1;
      end else begin
        overflow_q <= 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_i2s_sink.sv
module tb_i2s_sink;

  logic        clk = 1'b0;
  logic        reset_n, en0, en1, bck, lrck, sdata, out_ready;
  logic [47:0] od0, od1;
  logic        ov0, ov1, fe0, fe1, of0, of1;

  // dut0: I2S timing, dut1: left-justified
  i2s_sink #(.SAMPLE_BITS(24), .MSB_DELAY(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(en0), .bck(bck), .lrck(lrck), .sdata(sdata),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .frame_error(fe0), .overflow(of0)
  );

  i2s_sink #(.SAMPLE_BITS(24), .MSB_DELAY(0), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(en1), .bck(bck), .lrck(lrck), .sdata(sdata),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .frame_error(fe1), .overflow(of1)
  );

  always #5 clk = ~clk;  // 100 MHz; bck period 80 ns = 8x slower

  typedef struct {
    logic [23:0] left;
    logic [23:0] right;
    logic [47:0] exp;
  } vec_t;

  vec_t        vecs [5];
  logic [47:0] sb0 [$];
  logic [47:0] sb1 [$];
  int          checks = 0;
  int          errors = 0;
  int          fe_cnt0 = 0;
  int          fe_cnt1 = 0;
  int          valid_cycles0 = 0;
  int          fe_base, vc_base;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [47:0] act, input bit dut1_sel);
    logic [47:0] e;
    if ((dut1_sel ? sb1.size() : sb0.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h with no pair expected", name, act);
    end else begin
      e = dut1_sel ? sb1.pop_front() : sb0.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (fe0) fe_cnt0++;
      if (fe1) fe_cnt1++;
      if (ov0) valid_cycles0++;
      if (ov0 && out_ready) pop_check("pair0", od0, 1'b0);
      if (ov1 && out_ready) pop_check("pair1", od1, 1'b1);
    end
  endtask

  // Drives bck rises k0..k1-1 of a slot; lrck/sdata change with bck falling.
  task automatic drive_bits(input logic lr, input logic [23:0] word, input int k0, input int k1,
                            input int dly);
    for (int k = k0; k < k1; k++) begin
      bck  = 1'b0;
      lrck = lr;
      if (k >= dly && k < dly + 24) sdata = word[23-(k-dly)];
      else                          sdata = k[0];
      #40;
      bck = 1'b1;
      #40;
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nl, input int nr,
                            input int dly);
    drive_bits(1'b0, l, 0, nl, dly);
    drive_bits(1'b1, r, 0, nr, dly);
  endtask

  task automatic begin_seq(input logic e0, input logic e1);
    @(posedge clk);
    #2;
    en0 = e0;
    en1 = e1;
    drive_bits(1'b1, 24'h0, 0, 4, 1);
  endtask

  // The closing falling lrck edge completes the last pair; then drop back to IDLE.
  task automatic end_seq();
    drive_bits(1'b0, 24'h0, 0, 4, 1);
    bck = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    en0 = 1'b0;
    en1 = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 48'(ov0), 48'd0);
    check({tag, "_data"}, od0, 48'd0);
    check({tag, "_ferr"}, 48'(fe0), 48'd0);
    check({tag, "_ovf"}, 48'(of0), 48'd0);
  endtask

  initial begin
    vecs[0] = '{left: 24'hA5F00F, right: 24'h123456, exp: 48'hA5F00F123456};
    vecs[1] = '{left: 24'h000000, right: 24'hFFFFFF, exp: 48'h000000FFFFFF};
    vecs[2] = '{left: 24'hFFFFFF, right: 24'h000000, exp: 48'hFFFFFF000000};
    vecs[3] = '{left: 24'h800001, right: 24'h7FFFFF, exp: 48'h8000017FFFFF};
    vecs[4] = '{left: 24'h5A5A5A, right: 24'hC3C3C3, exp: 48'h5A5A5AC3C3C3};

    reset_n   = 1'b0;
    en0       = 1'b0;
    en1       = 1'b0;
    bck       = 1'b0;
    lrck      = 1'b0;
    sdata     = 1'b0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (5) @(posedge clk);
    #2;
    check_quiet("reset0");
    check("reset1_valid", 48'(ov1), 48'd0);
    check("reset1_data", od1, 48'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Table of normal frames, 64 bck per frame, consumer always ready
    fe_base = fe_cnt0;
    vc_base = valid_cycles0;
    begin_seq(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].left, vecs[i].right, 32, 32, 1);
      sb0.push_back(vecs[i].exp);
    end
    end_seq();
    check("table_drained", 48'(sb0.size()), 48'd0);
    check("table_valid_cycles", 48'(valid_cycles0 - vc_base), 48'd5);
    check("table_ferr", 48'(fe_cnt0 - fe_base), 48'd0);
    check("table_ovf", 48'(of0), 48'd0);

    // Backpressure: three pairs with the consumer stalled
    out_ready = 1'b0;
    begin_seq(1'b1, 1'b0);
    send_frame(24'h111111, 24'h222222, 32, 32, 1);
    sb0.push_back(48'h111111222222);
    send_frame(24'h333333, 24'h444444, 32, 32, 1);
    check("bp_valid_1", 48'(ov0), 48'd1);
    check("bp_data_1", od0, 48'h111111222222);
    check("bp_ovf_1", 48'(of0), 48'd0);
    send_frame(24'h555555, 24'h666666, 32, 32, 1);
    end_seq();
    check("bp_valid_2", 48'(ov0), 48'd1);
    check("bp_data_2", od0, 48'h111111222222);
    check("bp_ovf_2", 48'(of0), 48'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("bp_valid_after", 48'(ov0), 48'd0);
    check("bp_drained", 48'(sb0.size()), 48'd0);
    check("bp_ovf_sticky", 48'(of0), 48'd1);
    reset_n = 1'b0;
    #20;
    check("bp_ovf_reset", 48'(of0), 48'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Short left slot (16 bck), then a clean frame
    fe_base = fe_cnt0;
    begin_seq(1'b1, 1'b0);
    send_frame(24'hDEADBE, 24'hEF0123, 16, 32, 1);
    send_frame(24'h0F1E2D, 24'h3C4B5A, 32, 32, 1);
    sb0.push_back(48'h0F1E2D3C4B5A);
    end_seq();
    check("short_l_ferr", 48'(fe_cnt0 - fe_base), 48'd1);
    check("short_l_drained", 48'(sb0.size()), 48'd0);

    // Short right slot (16 bck), then a clean frame
    fe_base = fe_cnt0;
    begin_seq(1'b1, 1'b0);
    send_frame(24'hABCDEF, 24'h987654, 32, 16, 1);
    send_frame(24'h246802, 24'h135790, 32, 32, 1);
    sb0.push_back(48'h246802135790);
    end_seq();
    check("short_r_ferr", 48'(fe_cnt0 - fe_base), 48'd1);
    check("short_r_drained", 48'(sb0.size()), 48'd0);

    // Left-justified instance
    begin_seq(1'b0, 1'b1);
    send_frame(24'h800001, 24'h7FFFFF, 32, 32, 0);
    sb1.push_back(48'h8000017FFFFF);
    end_seq();
    check("lj_drained", 48'(sb1.size()), 48'd0);
    check("lj_ferr", 48'(fe_cnt1), 48'd0);
    check("lj_ovf", 48'(of1), 48'd0);

    // Reset during the right slot
    fe_base = fe_cnt0;
    begin_seq(1'b1, 1'b0);
    drive_bits(1'b0, 24'hFACE00, 0, 32, 1);
    drive_bits(1'b1, 24'h00CAFE, 0, 10, 1);
    reset_n = 1'b0;
    #20;
    check_quiet("midrst");
    reset_n = 1'b1;
    drive_bits(1'b1, 24'h00CAFE, 10, 32, 1);
    send_frame(24'h13579B, 24'hDF0246, 32, 32, 1);
    sb0.push_back(48'h13579BDF0246);
    end_seq();
    check("midrst_drained", 48'(sb0.size()), 48'd0);
    check("midrst_ferr", 48'(fe_cnt0 - fe_base), 48'd0);

    // Enable low for half a frame
    fe_base = fe_cnt0;
    begin_seq(1'b1, 1'b0);
    drive_bits(1'b0, 24'hAAAAAA, 0, 32, 1);
    drive_bits(1'b1, 24'hBBBBBB, 0, 16, 1);
    en0 = 1'b0;
    drive_bits(1'b1, 24'hBBBBBB, 16, 32, 1);
    drive_bits(1'b0, 24'hCCCCCC, 0, 16, 1);
    en0 = 1'b1;
    drive_bits(1'b0, 24'hCCCCCC, 16, 32, 1);
    drive_bits(1'b1, 24'hDDDDDD, 0, 32, 1);
    send_frame(24'h010203, 24'h040506, 32, 32, 1);
    sb0.push_back(48'h010203040506);
    end_seq();
    check("en_drained", 48'(sb0.size()), 48'd0);
    check("en_ovf", 48'(of0), 48'd0);
    check("en_ferr", 48'(fe_cnt0 - fe_base), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
